instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches words over req/ack and
// holds each instruction in IR until the control unit retires or redirects it.
module instr_fetch_unit #(
    parameter int unsigned         ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       IR,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC4,
    output logic [31:0]       retired
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;

    // mem_addr is kept separate from fetch_pc so an abandoned request keeps
    // its address stable while fetch_pc already points at the redirect target.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= '0;
            mem_req  <= 1'b0;
            IR       <= '0;
            ir_valid <= 1'b0;
            PC       <= '0;
            PC4      <= '0;
            retired  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= fetch_pc;
                end
                S_REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (mem_ack) begin
                            mem_addr <= redirect_pc;
                        end else begin
                            state <= S_DROP;
                        end
                    end else if (mem_ack) begin
                        IR       <= mem_rdata;
                        PC       <= fetch_pc;
                        PC4      <= fetch_pc + PC_STEP;
                        ir_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end
                    if (mem_ack) begin
                        state    <= S_REQ;
                        mem_addr <= redirect ? redirect_pc : fetch_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect || ir_ready) begin
                        state    <= S_REQ;
                        ir_valid <= 1'b0;
                        mem_req  <= 1'b1;
                        if (ir_ready) begin
                            retired <= retired + 32'd1;
                        end
                        if (redirect) begin
                            fetch_pc <= redirect_pc;
                            mem_addr <= redirect_pc;
                        end else begin
                            fetch_pc <= fetch_pc + PC_STEP;
                            mem_addr <= fetch_pc + PC_STEP;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch/redirect/reset scenarios
// against a latency-programmable memory model.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 64;

    logic              clock;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic [31:0]       IR;
    logic              ir_valid;
    logic              ir_ready = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic [ADDR_W-1:0] PC;
    logic [ADDR_W-1:0] PC4;
    logic [31:0]       retired;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .IR          (IR),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .PC          (PC),
        .PC4         (PC4),
        .retired     (retired)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0]       ir;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc4;
    } exp_ir_t;

    logic [ADDR_W-1:0] exp_addr_q[$];
    exp_ir_t           exp_ir_q[$];

    int total = 0;
    int bad   = 0;
    int lat   = 1;   // ack in the lat-th request cycle; 0 stalls forever

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == '0) return 32'h8B02_0020;
        return {16'hE000, a[15:0]};
    endfunction

    // Memory model, reset together with the DUT
    int cnt = 0;
    always begin
        @(posedge clock);
        #2;
        mem_ack = 1'b0;
        if (reset) begin
            cnt = 0;
        end else if (mem_req) begin
            cnt++;
            if (lat != 0 && cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                cnt       = 0;
            end
        end
    end

    // Monitor: handshake addresses, IR presentations, request stability
    logic prev_valid = 1'b0;
    logic prev_out   = 1'b0;
    always @(negedge clock) begin
        if (prev_out) check("req_held", 64'(mem_req), 64'd1);
        if (mem_req === 1'b1 && mem_ack) begin
            if (exp_addr_q.size() == 0) check("unexpected_ack_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("ack_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (ir_valid === 1'b1 && !prev_valid) begin
            if (exp_ir_q.size() == 0) begin
                check("unexpected_ir", 64'(IR), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_ir_t e;
                e = exp_ir_q.pop_front();
                check("ir_word", 64'(IR), 64'(e.ir));
                check("ir_pc",   PC,  e.pc);
                check("ir_pc4",  PC4, e.pc4);
            end
        end
        prev_valid = (ir_valid === 1'b1);
        prev_out   = (mem_req === 1'b1) && !mem_ack && !reset;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50; i++) begin
            if (ir_valid) return;
            tick();
        end
        check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic pulse_ready();
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
    endtask

    task automatic push_addr(input logic [ADDR_W-1:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic push_ir(input logic [31:0] w, input logic [ADDR_W-1:0] pc);
        exp_ir_t e;
        e.ir  = w;
        e.pc  = pc;
        e.pc4 = pc + 64'd4;
        exp_ir_q.push_back(e);
    endtask

    initial begin
        // Reset values and zero-wait first fetch
        lat = 1;
        do_reset();
        check("rst_mem_req",  64'(mem_req),  64'd0);
        check("rst_mem_addr", mem_addr,      64'd0);
        check("rst_ir_valid", 64'(ir_valid), 64'd0);
        check("rst_ir",       64'(IR),       64'd0);
        check("rst_pc4",      PC4,           64'd0);
        check("rst_retired",  64'(retired),  64'd0);
        push_addr(64'h0);
        push_ir(32'h8B02_0020, 64'h0);
        tick();
        check("t1_req_c1",   64'(mem_req),  64'd1);
        check("t1_addr_c1",  mem_addr,      64'd0);
        tick();
        check("t1_valid_c2", 64'(ir_valid), 64'd1);
        check("t1_ir_c2",    64'(IR),       64'h8B02_0020);
        check("t1_pc4_c2",   PC4,           64'd4);
        repeat (5) tick();
        check("t1_hold_valid", 64'(ir_valid), 64'd1);
        check("t1_hold_req",   64'(mem_req),  64'd0);

        // Four sequential fetches at latency 3
        lat = 3;
        do_reset();
        push_addr(64'h0); push_addr(64'h4); push_addr(64'h8); push_addr(64'hC);
        push_ir(32'h8B02_0020, 64'h0);
        push_ir(32'hE000_0004, 64'h4);
        push_ir(32'hE000_0008, 64'h8);
        push_ir(32'hE000_000C, 64'hC);
        for (int k = 0; k < 4; k++) begin
            wait_valid("t2_fetch");
            if (k == 3) lat = 0;
            pulse_ready();
        end
        check("t2_retired",  64'(retired), 64'd4);
        check("t2_next_req", 64'(mem_req), 64'd1);
        check("t2_next_addr", mem_addr,    64'h10);

        // Redirect with ir_ready in S_HOLD at PC=8
        lat = 1;
        do_reset();
        push_addr(64'h0); push_addr(64'h4); push_addr(64'h8); push_addr(64'h40);
        push_ir(32'h8B02_0020, 64'h0);
        push_ir(32'hE000_0004, 64'h4);
        push_ir(32'hE000_0008, 64'h8);
        push_ir(32'hE000_0040, 64'h40);
        wait_valid("t3_f0"); pulse_ready();
        wait_valid("t3_f1"); pulse_ready();
        wait_valid("t3_f2");
        check("t3_pc_before", PC, 64'h8);
        ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h40;
        tick();
        ir_ready = 1'b0; redirect = 1'b0;
        check("t3_addr",    mem_addr,      64'h40);
        check("t3_valid",   64'(ir_valid), 64'd0);
        check("t3_retired", 64'(retired),  64'd3);
        wait_valid("t3_f3");
        check("t3_pc4", PC4, 64'h44);
        lat = 0;

        // Redirect during an outstanding 3-cycle request at addr 4
        lat = 1;
        do_reset();
        push_addr(64'h0); push_addr(64'h4); push_addr(64'h100);
        push_ir(32'h8B02_0020, 64'h0);
        push_ir(32'hE000_0100, 64'h100);
        wait_valid("t4_f0");
        lat = 3;
        pulse_ready();
        redirect = 1'b1; redirect_pc = 64'h100;
        tick();
        redirect = 1'b0;
        check("t4_drop_addr_a", mem_addr, 64'h4);
        tick();
        check("t4_drop_addr_b", mem_addr,     64'h4);
        check("t4_drop_req",    64'(mem_req), 64'd1);
        tick();
        check("t4_new_addr", mem_addr, 64'h100);
        wait_valid("t4_f1");
        check("t4_pc", PC, 64'h100);

        // Redirect coincident with mem_ack in S_REQ
        lat = 2;
        do_reset();
        push_addr(64'h0); push_addr(64'h200);
        push_ir(32'hE000_0200, 64'h200);
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 64'h200;
        tick();
        redirect = 1'b0;
        check("t5_valid", 64'(ir_valid), 64'd0);
        check("t5_ir",    64'(IR),       64'd0);
        check("t5_req",   64'(mem_req),  64'd1);
        check("t5_addr",  mem_addr,      64'h200);
        wait_valid("t5_f1");

        // Reset asserted while in S_DROP
        lat = 0;
        pulse_ready();
        check("t6_retired", 64'(retired), 64'd1);
        check("t6_addr",    mem_addr,     64'h204);
        redirect = 1'b1; redirect_pc = 64'h300;
        tick();
        redirect = 1'b0;
        check("t6_drop_addr", mem_addr, 64'h204);
        reset = 1'b1;
        tick();
        check("t6_rst_req",     64'(mem_req),  64'd0);
        check("t6_rst_addr",    mem_addr,      64'd0);
        check("t6_rst_ir",      64'(IR),       64'd0);
        check("t6_rst_pc",      PC,            64'd0);
        check("t6_rst_pc4",     PC4,           64'd0);
        check("t6_rst_retired", 64'(retired),  64'd0);
        reset = 1'b0;
        lat = 1;
        push_addr(64'h0);
        push_ir(32'h8B02_0020, 64'h0);
        tick();
        check("t6_restart_req",  64'(mem_req), 64'd1);
        check("t6_restart_addr", mem_addr,     64'd0);
        wait_valid("t6_f0");
        repeat (3) tick();

        check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        check("ir_q_empty",   64'(exp_ir_q.size()),   64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
